// File: rtl/flux_capture_pkg.sv
// flux_capture_pkg: shared state encoding, overflow word and width check
// for the flux_capture disk-flux timing capture block.
package flux_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int BITS_MIN = 4;
    localparam int BITS_MAX = 32;

    function automatic bit bits_ok(input int bits);
        return (bits >= BITS_MIN) && (bits <= BITS_MAX);
    endfunction

    // Overflow word: MSB clear, every interval bit set.
    function automatic logic [31:0] ovf_code(input int bits);
        return 32'((64'd1 << (bits - 1)) - 64'd1);
    endfunction

endpackage

// File: rtl/flux_capture_if.sv
// flux_capture_if: captured-word handshake towards the RAM writer.
// A word moves when WRITE and READY are both high.
interface flux_capture_if #(
    parameter int BITS = 16
);
    logic [BITS-1:0] DATA;
    logic            WRITE;
    logic            READY;

    modport master (
        output DATA,
        output WRITE,
        input  READY
    );

    modport slave (
        input  DATA,
        input  WRITE,
        output READY
    );
endinterface

// File: rtl/flux_pulse_sync.sv
// flux_pulse_sync: multi-flop synchroniser for an asynchronous pulse,
// producing a one-cycle event on each rising edge.
module flux_pulse_sync #(
    parameter int STAGES = 2
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic async_in,
    output logic pulse
);
    logic [STAGES-1:0] sync_q;
    logic              last_q;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            last_q <= sync_q[STAGES-1];
        end
    end

    assign pulse = sync_q[STAGES-1] & ~last_q;
endmodule

// File: rtl/flux_capture.sv
// flux_capture: timestamps flux read/index pulses into BITS-wide words.
// Define FLUX_CAPTURE_INDEX_STOP_EN to enable auto-stop after N index edges.
module flux_capture
    import flux_capture_pkg::*;
#(
    parameter int BITS        = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic           CLOCK,
    input  logic           RESET,
    input  logic           CLKEN,
    input  logic           RUN,
    input  logic           START_ON_INDEX,
    input  logic [7:0]     INDEX_STOP_COUNT,
    input  logic           FD_RDDATA_IN,
    input  logic           FD_INDEX_IN,
    flux_capture_if.master ram,
    output logic           BUSY,
    output logic           DONE,
    output logic           LOST
);
    localparam int CW = BITS - 1;
    localparam logic [CW-1:0] CMAX = CW'((64'd1 << CW) - 64'd2);

    if (!bits_ok(BITS)) begin : g_bits_bad
        $error("flux_capture: BITS out of range");
    end

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic            run_q, ix_prev_q;
    logic [BITS-1:0] data_q, skid_q;
    logic            wr_q, skid_v_q, lost_q;

    logic            rd_ev, ix_ev, run_rise;
    logic            word_vld, cnt_clr, cnt_inc;
    logic            lost_clr, cfg_load, idx_one, idx_inc;
    logic            stop_hit, arm_stop, out_free;
    logic [BITS-1:0] word;

    flux_pulse_sync #(.STAGES(SYNC_STAGES)) u_rd_sync (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .async_in (FD_RDDATA_IN),
        .pulse    (rd_ev)
    );

    flux_pulse_sync #(.STAGES(SYNC_STAGES)) u_ix_sync (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .async_in (FD_INDEX_IN),
        .pulse    (ix_ev)
    );

    assign run_rise = RUN & ~run_q;

`ifdef FLUX_CAPTURE_INDEX_STOP_EN
    logic [7:0] stop_q, idx_q;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            stop_q <= '0;
            idx_q  <= '0;
        end else if (cfg_load) begin
            stop_q <= INDEX_STOP_COUNT;
            idx_q  <= '0;
        end else if (idx_one) begin
            idx_q <= 8'd1;
        end else if (idx_inc) begin
            idx_q <= idx_q + 8'd1;
        end
    end

    assign stop_hit = ix_ev && (stop_q != 8'd0) && (idx_q + 8'd1 == stop_q);
    assign arm_stop = (stop_q == 8'd1);
`else
    logic unused_stop;
    assign unused_stop = ^{INDEX_STOP_COUNT, cfg_load, idx_one, idx_inc};
    assign stop_hit    = 1'b0;
    assign arm_stop    = 1'b0;
`endif

    always_ff @(posedge CLOCK) begin
        if (RESET) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        word_vld = 1'b0;
        word     = '0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        lost_clr = 1'b0;
        cfg_load = 1'b0;
        idx_one  = 1'b0;
        idx_inc  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (run_rise) begin
                    cfg_load = 1'b1;
                    lost_clr = 1'b1;
                    cnt_clr  = 1'b1;
                    state_d  = START_ON_INDEX ? ST_ARMED : ST_CAPTURE;
                end
            end
            ST_ARMED: begin
                if (!RUN) begin
                    state_d = ST_DONE;
                end else if (ix_ev) begin
                    cnt_clr = 1'b1;
                    idx_one = 1'b1;
                    state_d = arm_stop ? ST_DRAIN : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                // An edge always wins over a simultaneous overflow.
                if (rd_ev || ix_ev) begin
                    word_vld = 1'b1;
                    word     = {ix_ev | ix_prev_q, cnt_q};
                    cnt_clr  = 1'b1;
                end else if (CLKEN && (cnt_q == CMAX)) begin
                    word_vld = 1'b1;
                    word     = BITS'(ovf_code(BITS));
                    cnt_clr  = 1'b1;
                end else if (CLKEN) begin
                    cnt_inc = 1'b1;
                end
                idx_inc = ix_ev;
                if (!RUN || stop_hit) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!skid_v_q && !wr_q) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!RUN) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign out_free = !wr_q || ram.READY;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            cnt_q     <= '0;
            run_q     <= 1'b0;
            ix_prev_q <= 1'b0;
            data_q    <= '0;
            wr_q      <= 1'b0;
            skid_q    <= '0;
            skid_v_q  <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            run_q     <= RUN;
            ix_prev_q <= ix_ev;
            if (cnt_clr)      cnt_q <= '0;
            else if (cnt_inc) cnt_q <= cnt_q + CW'(1);
            if (lost_clr) lost_q <= 1'b0;
            // The skid word is always older than a new one, so it goes first.
            if (out_free) begin
                if (skid_v_q) begin
                    data_q   <= skid_q;
                    wr_q     <= 1'b1;
                    skid_q   <= word;
                    skid_v_q <= word_vld;
                end else if (word_vld) begin
                    data_q <= word;
                    wr_q   <= 1'b1;
                end else begin
                    wr_q <= 1'b0;
                end
            end else if (word_vld) begin
                if (!skid_v_q) begin
                    skid_q   <= word;
                    skid_v_q <= 1'b1;
                end else begin
                    lost_q <= 1'b1;
                end
            end
        end
    end

    assign ram.DATA  = data_q;
    assign ram.WRITE = wr_q;
    assign BUSY = (state_q == ST_ARMED) || (state_q == ST_CAPTURE) ||
                  (state_q == ST_DRAIN);
    assign DONE = (state_q == ST_DONE);
    assign LOST = lost_q;
endmodule

// File: tb/tb_flux_capture.sv
// tb_flux_capture: scoreboard bench for flux_capture (BITS=16, 2 sync flops).
// Expected words are queued as pulses are driven and checked on transfer.
module tb_flux_capture;
    logic       CLOCK = 1'b0;
    logic       RESET;
    logic       CLKEN;
    logic       RUN;
    logic       START_ON_INDEX;
    logic [7:0] INDEX_STOP_COUNT;
    logic       FD_RDDATA_IN;
    logic       FD_INDEX_IN;
    logic       BUSY, DONE, LOST;

    flux_capture_if #(.BITS(16)) bus ();

    flux_capture #(.BITS(16), .SYNC_STAGES(2)) dut (
        .CLOCK            (CLOCK),
        .RESET            (RESET),
        .CLKEN            (CLKEN),
        .RUN              (RUN),
        .START_ON_INDEX   (START_ON_INDEX),
        .INDEX_STOP_COUNT (INDEX_STOP_COUNT),
        .FD_RDDATA_IN     (FD_RDDATA_IN),
        .FD_INDEX_IN      (FD_INDEX_IN),
        .ram              (bus),
        .BUSY             (BUSY),
        .DONE             (DONE),
        .LOST             (LOST)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [15:0] v;
        bit          alt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   base  = 0;

    always @(posedge CLOCK) cyc <= cyc + 1;

    // A word transfers at the next rising edge; compare it half a cycle early.
    always @(negedge CLOCK) begin : mon
        exp_t e;
        if (!RESET && bus.WRITE && bus.READY) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL word_unexpected: got %h, required none", bus.DATA);
            end else begin
                e = exp_q.pop_front();
                if (e.alt) begin
                    if (bus.DATA !== 16'h0063 && bus.DATA !== 16'h0064) begin
                        bad++;
                        $display("FAIL word_first: got %h, required 0063 or 0064", bus.DATA);
                    end
                end else if (bus.DATA !== e.v) begin
                    bad++;
                    $display("FAIL word: got %h, required %h", bus.DATA, e.v);
                end
            end
        end
    end

    task automatic at(input int n);
        while (cyc < n) begin
            @(posedge CLOCK);
            #1;
        end
    endtask

    task automatic push(input logic [15:0] v, input bit alt);
        exp_t e;
        e.v   = v;
        e.alt = alt;
        exp_q.push_back(e);
    endtask

    task automatic pulse_at(input int t, input bit rd, input bit ix);
        at(t);
        FD_RDDATA_IN = rd;
        FD_INDEX_IN  = ix;
        at(t + 2);
        FD_RDDATA_IN = 1'b0;
        FD_INDEX_IN  = 1'b0;
    endtask

    task automatic start_run(input bit soi, input logic [7:0] stop_n);
        START_ON_INDEX   = soi;
        INDEX_STOP_COUNT = stop_n;
        RUN              = 1'b1;
        base             = cyc;
    endtask

    task automatic stop_run();
        RUN = 1'b0;
        for (int i = 0; i < 300 && (BUSY || DONE); i++) begin
            @(posedge CLOCK);
            #1;
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(posedge CLOCK);
        #1;
        total++;
        if (bus.WRITE !== 1'b0) begin
            bad++; $display("FAIL rst_write: got %b, required 0", bus.WRITE);
        end
        total++;
        if (bus.DATA !== 16'h0000) begin
            bad++; $display("FAIL rst_data: got %h, required 0000", bus.DATA);
        end
        total++;
        if (BUSY !== 1'b0) begin
            bad++; $display("FAIL rst_busy: got %b, required 0", BUSY);
        end
        total++;
        if (DONE !== 1'b0) begin
            bad++; $display("FAIL rst_done: got %b, required 0", DONE);
        end
        total++;
        if (LOST !== 1'b0) begin
            bad++; $display("FAIL rst_lost: got %b, required 0", LOST);
        end
        RESET = 1'b0;
        @(posedge CLOCK);
        #1;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
            @(posedge CLOCK);
            #1;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: got %0d pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_period();
        start_run(1'b0, 8'd0);
        push(16'h0063, 1'b1);
        pulse_at(base + 98, 1'b1, 1'b0);
        for (int k = 1; k < 4; k++) begin
            push(16'h0063, 1'b0);
            pulse_at(base + 98 + 100 * k, 1'b1, 1'b0);
        end
        total++;
        if (BUSY !== 1'b1) begin
            bad++; $display("FAIL period_busy: got %b, required 1", BUSY);
        end
        wait_drain("period");
        stop_run();
        total++;
        if (BUSY !== 1'b0 || DONE !== 1'b0) begin
            bad++; $display("FAIL period_idle: got busy=%b done=%b, required 0 0", BUSY, DONE);
        end
    endtask

    task automatic test_clken();
        CLKEN = 1'b0;
        start_run(1'b0, 8'd0);
        push(16'h0000, 1'b0);
        pulse_at(base + 20, 1'b1, 1'b0);
        at(base + 40);
        CLKEN = 1'b1;
        push(16'h0016, 1'b0);
        pulse_at(base + 60, 1'b1, 1'b0);
        wait_drain("clken");
        stop_run();
    endtask

    task automatic test_same_cycle();
        start_run(1'b0, 8'd0);
        push(16'h800A, 1'b0);
        pulse_at(base + 9, 1'b1, 1'b1);
        push(16'h0031, 1'b0);
        pulse_at(base + 59, 1'b1, 1'b0);
        push(16'h8031, 1'b0);
        pulse_at(base + 109, 1'b0, 1'b1);
        wait_drain("same");
        stop_run();
    endtask

    task automatic test_overflow();
        start_run(1'b0, 8'd0);
        push(16'h7FFF, 1'b0);
        push(16'h000B, 1'b0);
        pulse_at(base + 32777, 1'b1, 1'b0);
        wait_drain("ovf");
        stop_run();
    endtask

    task automatic test_index_stop();
        start_run(1'b1, 8'd3);
        pulse_at(base + 5, 1'b1, 1'b0);
        pulse_at(base + 20, 1'b0, 1'b1);
        push(16'h0013, 1'b0);
        pulse_at(base + 40, 1'b1, 1'b0);
        push(16'h8013, 1'b0);
        pulse_at(base + 60, 1'b0, 1'b1);
        push(16'h8013, 1'b0);
        pulse_at(base + 80, 1'b0, 1'b1);
        at(base + 95);
`ifdef FLUX_CAPTURE_INDEX_STOP_EN
        total++;
        if (DONE !== 1'b1) begin
            bad++; $display("FAIL stop_done: got %b, required 1", DONE);
        end
        pulse_at(base + 100, 1'b1, 1'b0);
        at(base + 110);
        total++;
        if (DONE !== 1'b1 || BUSY !== 1'b0) begin
            bad++; $display("FAIL stop_hold: got done=%b busy=%b, required 1 0", DONE, BUSY);
        end
`else
        total++;
        if (BUSY !== 1'b1 || DONE !== 1'b0) begin
            bad++; $display("FAIL nostop_busy: got busy=%b done=%b, required 1 0", BUSY, DONE);
        end
        push(16'h0013, 1'b0);
        pulse_at(base + 100, 1'b1, 1'b0);
`endif
        wait_drain("stop");
        stop_run();
    endtask

    task automatic test_back_to_back();
        bus.READY = 1'b0;
        start_run(1'b0, 8'd0);
        push(16'h000A, 1'b0);
        pulse_at(base + 9, 1'b1, 1'b0);
        push(16'h0013, 1'b0);
        pulse_at(base + 29, 1'b1, 1'b0);
        pulse_at(base + 59, 1'b1, 1'b0);
        at(base + 70);
        total++;
        if (bus.WRITE !== 1'b1 || bus.DATA !== 16'h000A) begin
            bad++; $display("FAIL bp_hold: got write=%b data=%h, required 1 000a", bus.WRITE, bus.DATA);
        end
        total++;
        if (LOST !== 1'b1) begin
            bad++; $display("FAIL bp_lost: got %b, required 1", LOST);
        end
        bus.READY = 1'b1;
        wait_drain("bp");
        stop_run();
        total++;
        if (LOST !== 1'b1) begin
            bad++; $display("FAIL bp_sticky: got %b, required 1", LOST);
        end
    endtask

    task automatic test_reset_mid();
        bus.READY = 1'b0;
        start_run(1'b0, 8'd0);
        pulse_at(base + 9, 1'b1, 1'b0);
        at(base + 14);
        total++;
        if (bus.WRITE !== 1'b1 || BUSY !== 1'b1) begin
            bad++; $display("FAIL mid_pending: got write=%b busy=%b, required 1 1", bus.WRITE, BUSY);
        end
        total++;
        if (LOST !== 1'b0) begin
            bad++; $display("FAIL mid_lost_clr: got %b, required 0", LOST);
        end
        RESET = 1'b1;
        RUN   = 1'b0;
        @(posedge CLOCK);
        #1;
        total++;
        if (bus.WRITE !== 1'b0) begin
            bad++; $display("FAIL mid_write: got %b, required 0", bus.WRITE);
        end
        total++;
        if (BUSY !== 1'b0 || DONE !== 1'b0) begin
            bad++; $display("FAIL mid_idle: got busy=%b done=%b, required 0 0", BUSY, DONE);
        end
        RESET     = 1'b0;
        bus.READY = 1'b1;
        repeat (5) @(posedge CLOCK);
        #1;
    endtask

    initial begin
        RESET            = 1'b1;
        CLKEN            = 1'b1;
        RUN              = 1'b0;
        START_ON_INDEX   = 1'b0;
        INDEX_STOP_COUNT = 8'd0;
        FD_RDDATA_IN     = 1'b0;
        FD_INDEX_IN      = 1'b0;
        bus.READY        = 1'b1;
        test_reset();
        test_period();
        test_clken();
        test_same_cycle();
        test_overflow();
        test_index_stop();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/flux_capture.md
FLUX_CAPTURE -- requirements
Module: flux_capture

Interface
REQ-001 SHALL have parameter BITS, default 16, output word width; legal range 4..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth; legal range 2..4.
REQ-003 SHALL have port CLOCK  input  1  capture clock; all logic on its rising edge.
REQ-004 SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port CLKEN  input  1  counter clock enable (timebase divider).
REQ-006 SHALL have port RUN  input  1  1 = acquire; 0 = stop at next cycle.
REQ-007 SHALL have port START_ON_INDEX  input  1  1 = hold off until first index edge; sampled on RUN rising.
REQ-008 SHALL have port INDEX_STOP_COUNT  input  8  index edges before auto-stop; 0 = unlimited; sampled on RUN rising.
REQ-009 SHALL have port FD_RDDATA_IN  input  1  asynchronous read-data pulse.
REQ-010 SHALL have port FD_INDEX_IN  input  1  asynchronous index pulse.
REQ-011 SHALL have port READY  input  1  RAM side accepts a word when high.
REQ-012 SHALL have port DATA  output  BITS  captured word.
REQ-013 SHALL have port WRITE  output  1  word valid; transfer completes when WRITE and READY are both high.
REQ-014 SHALL have port BUSY  output  1  high in ARMED, CAPTURE or DRAIN.
REQ-015 SHALL have port DONE  output  1  high in DONE state.
REQ-016 SHALL have port LOST  output  1  sticky; a word was dropped.

Function
REQ-017 SHALL synchronise each pulse input through SYNC_STAGES flops; a rising edge of the synchronised signal yields a one-cycle event.
REQ-018 SHALL keep counter width BITS-1 and max value 2^(BITS-1)-2; it increments only when CLKEN is high.
REQ-019 SHALL, on a data or index event in CAPTURE, emit a word with DATA[BITS-2:0]=counter and DATA[BITS-1]=index event this cycle or previous cycle; the counter goes to 0 this cycle.
REQ-020 SHALL, when counter=max with CLKEN and no event, emit the overflow word (MSB 0, low bits all ones) and wrap the counter to 0.
REQ-021 SHALL give an event priority over overflow in the same cycle; only one word is produced.
REQ-022 SHALL use states IDLE, ARMED, CAPTURE, DRAIN, DONE.
REQ-023 IDLE->ARMED on RUN rising when START_ON_INDEX=1; IDLE->CAPTURE on RUN rising otherwise; counter cleared on entry.
REQ-024 ARMED->CAPTURE on the first index event; that edge emits no word and counts as index 1.
REQ-025 CAPTURE->DRAIN when RUN falls or the stop condition (REQ-035) is met; ARMED->DONE when RUN falls.
REQ-026 DRAIN->DONE once no word is pending; DONE->IDLE when RUN is low.
REQ-027 SHALL latch the word into an output register: WRITE rises the cycle after the event (latency 1) and holds DATA stable until READY.
REQ-028 SHALL add one skid entry: a word produced while the output register is full and READY is low goes to skid; if skid is also full the word is dropped and LOST is set.
REQ-029 SHALL clear LOST only on RESET or on leaving IDLE.

Reset
REQ-030 SHALL, on RESET, go to IDLE and clear counter, skid, synchronisers, DATA=0, WRITE=0, BUSY=0, DONE=0, LOST=0.
REQ-031 SHALL give RESET priority over all other inputs; a RESET mid-capture discards pending words with no WRITE in the next cycle.

Configuration
REQ-032 SHALL use macro FLUX_CAPTURE_INDEX_STOP_EN to gate auto-stop.
REQ-033 With the macro defined: the index counter is 8-bit and stop is evaluated on each index event.
REQ-034 Without the macro: INDEX_STOP_COUNT is ignored and only RUN falling ends capture.
REQ-035 Stop condition: index count equals a nonzero INDEX_STOP_COUNT; the terminating index word is still emitted.

Structure
REQ-036 SHALL place state enum, overflow-code function and BITS range check in package flux_capture_pkg.
REQ-037 SHALL implement the synchroniser and edge detector as sub-module flux_pulse_sync, one instance per input.

Verification
REQ-038 BITS=16, READY=1, read pulse every 100 enabled ticks -> words 0x0063 (99) or 0x0064 per the first-edge alignment, then steady 0x0063.
REQ-039 No pulses for 32767 ticks -> word 0x7FFF; counter restarts at 0.
REQ-040 Read and index event in the same cycle -> single word with MSB=1.
REQ-041 START_ON_INDEX=1, INDEX_STOP_COUNT=3, macro defined -> no words before index 1; DONE after the word for index 3.
REQ-042 READY=0 while 3 events occur -> first two words delivered in order after READY=1; LOST=1.
REQ-043 RESET asserted in CAPTURE with a pending word -> WRITE=0 and state IDLE the next cycle.
